// File: rtl/zl_ts_aligner_pkg.sv
// rtl/zl_ts_aligner_pkg.sv - shared constants and types for the MPEG-TS aligner
// Purpose: TS framing constants, null-packet header bytes, FSM/mode enums and
//          the packet position increment helper.
// Ports:   none (package)
package zl_ts_aligner_pkg;

   localparam int TS_POS_WIDTH  = 8;
   localparam int TS_PACKET_LEN = 188;

   localparam logic [7:0] TS_SYNC_BYTE = 8'h47;
   localparam logic [7:0] TS_NULL_HDR1 = 8'h1F;
   localparam logic [7:0] TS_NULL_HDR2 = 8'hFF;
   localparam logic [7:0] TS_NULL_HDR3 = 8'h10;
   localparam logic [7:0] TS_NULL_FILL = 8'hFF;

   localparam logic [TS_POS_WIDTH-1:0] TS_LAST_POS = TS_POS_WIDTH'(TS_PACKET_LEN - 1);

   typedef enum logic [1:0] {
      ST_HUNT   = 2'd0,
      ST_VERIFY = 2'd1,
      ST_LOCKED = 2'd2
   } state_t;

   typedef enum logic {
      MODE_PASS = 1'b0,
      MODE_NULL = 1'b1
   } mode_t;

   // Byte position inside a packet, wrapping after the last byte.
   function automatic logic [TS_POS_WIDTH-1:0] pos_inc(input logic [TS_POS_WIDTH-1:0] pos);
      return (pos == TS_LAST_POS) ? '0 : pos + 1'b1;
   endfunction

endpackage

// File: rtl/zl_ts_aligner_null_rom.sv
// rtl/zl_ts_aligner_null_rom.sv - byte lookup for a null packet (PID 0x1FFF)
// Purpose: maps a packet position to the null-packet byte at that position.
// Ports:   pos       in  8  position within the packet (0..187)
//          null_byte out 8  null-packet byte at pos
module zl_ts_null_rom
   import zl_ts_aligner_pkg::*;
(
   input  logic [TS_POS_WIDTH-1:0] pos,
   output logic [7:0]              null_byte
);

   always_comb begin
      null_byte = TS_NULL_FILL;
      case (pos)
         8'd0:    null_byte = TS_SYNC_BYTE;
         8'd1:    null_byte = TS_NULL_HDR1;
         8'd2:    null_byte = TS_NULL_HDR2;
         8'd3:    null_byte = TS_NULL_HDR3;
         default: null_byte = TS_NULL_FILL;
      endcase
   end

endmodule

// File: rtl/zl_ts_aligner.sv
// rtl/zl_ts_aligner.sv - MPEG-TS packet aligner and null-packet inserter
// Purpose: hunts for 188-byte TS framing in a raw byte stream, forwards whole
//          packets once locked and fills starved packet slots with null packets.
// Ports:   clk          in  1  system clock
//          rst_n        in  1  asynchronous active-low reset
//          data_in      in  8  input byte, valid while data_in_req=1
//          data_in_req  in  1  upstream has a byte
//          data_in_ack  out 1  input byte consumed this cycle
//          data_out     out 8  output byte
//          data_out_req out 1  data_out valid
//          data_out_ack in  1  downstream consumes data_out this cycle
//          locked       out 1  aligner is in LOCKED state
//          null_pkt     out 1  pulse when a null packet's sync byte transfers
//          sync_err     out 1  pulse when a locked boundary byte is not 0x47
module zl_ts_aligner
   import zl_ts_aligner_pkg::*;
#(
   parameter int Lock_count     = 3,
   parameter int Unlock_count   = 3,
   parameter bit Null_insert_en = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] data_in,
   input  logic       data_in_req,
   output logic       data_in_ack,
   output logic [7:0] data_out,
   output logic       data_out_req,
   input  logic       data_out_ack,
   output logic       locked,
   output logic       null_pkt,
   output logic       sync_err
);

   localparam logic [7:0] HITS_TO_LOCK    = 8'(Lock_count - 1);
   localparam logic [7:0] MISSES_TO_UNLOCK = 8'(Unlock_count - 1);

   state_t                  state_q, state_d;
   mode_t                   mode_q, mode_d;
   logic [TS_POS_WIDTH-1:0] pos_q, pos_d;
   logic [7:0]              hits_q, hits_d;
   logic [7:0]              misses_q, misses_d;
   logic [7:0]              null_byte;
   logic                    is_sync;

   zl_ts_null_rom u_null_rom (
      .pos       (pos_q),
      .null_byte (null_byte)
   );

   assign is_sync = (data_in == TS_SYNC_BYTE);
   assign locked  = (state_q == ST_LOCKED);

   always_comb begin
      state_d      = state_q;
      mode_d       = mode_q;
      pos_d        = pos_q;
      hits_d       = hits_q;
      misses_d     = misses_q;
      data_in_ack  = 1'b0;
      data_out_req = 1'b0;
      data_out     = 8'h00;
      null_pkt     = 1'b0;
      sync_err     = 1'b0;

      case (state_q)
         ST_HUNT: begin
            data_in_ack = data_in_req;
            if (data_in_req && is_sync) begin
               state_d = ST_VERIFY;
               pos_d   = 8'd1;
               hits_d  = 8'd1;
            end
         end

         ST_VERIFY: begin
            if (data_in_req) begin
               if (pos_q != '0) begin
                  data_in_ack = 1'b1;
                  pos_d       = pos_inc(pos_q);
               end else if (is_sync) begin
                  if (hits_q == HITS_TO_LOCK) begin
                     // Leave the confirming sync byte in place: it becomes the
                     // first output byte of the first forwarded packet.
                     state_d  = ST_LOCKED;
                     pos_d    = '0;
                     misses_d = 8'd0;
                     mode_d   = MODE_PASS;
                  end else begin
                     data_in_ack = 1'b1;
                     hits_d      = hits_q + 8'd1;
                     pos_d       = 8'd1;
                  end
               end else begin
                  data_in_ack = 1'b1;
                  state_d     = ST_HUNT;
                  pos_d       = '0;
                  hits_d      = 8'd0;
               end
            end
         end

         ST_LOCKED: begin
            if (pos_q == '0) begin
               data_out = TS_SYNC_BYTE;
               if (data_in_req && !is_sync && (misses_q == MISSES_TO_UNLOCK)) begin
                  // Losing lock: nothing goes out so no orphan sync byte reaches
                  // the modulator, and the bad byte is left for HUNT to discard.
                  state_d  = ST_HUNT;
                  pos_d    = '0;
                  hits_d   = 8'd0;
                  misses_d = 8'd0;
               end else if (data_in_req) begin
                  data_out_req = 1'b1;
                  data_in_ack  = data_out_ack;
                  if (data_out_ack) begin
                     pos_d  = 8'd1;
                     mode_d = MODE_PASS;
                     if (is_sync) begin
                        misses_d = 8'd0;
                     end else begin
                        sync_err = 1'b1;
                        misses_d = misses_q + 8'd1;
                     end
                  end
               end else if (Null_insert_en) begin
                  data_out_req = 1'b1;
                  if (data_out_ack) begin
                     pos_d    = 8'd1;
                     mode_d   = MODE_NULL;
                     null_pkt = 1'b1;
                  end
               end
            end else if (mode_q == MODE_PASS) begin
               data_out     = data_in;
               data_out_req = data_in_req;
               data_in_ack  = data_in_req & data_out_ack;
               if (data_in_req && data_out_ack) begin
                  pos_d = pos_inc(pos_q);
               end
            end else begin
               data_out_req = 1'b1;
               data_out     = null_byte;
               if (data_out_ack) begin
                  pos_d = pos_inc(pos_q);
               end
            end
         end

         default: begin
            state_d = ST_HUNT;
            pos_d   = '0;
         end
      endcase

      // State is cleared asynchronously; this also keeps the strobes quiet for
      // as long as reset is held, since HUNT would otherwise pop every byte.
      if (!rst_n) begin
         data_in_ack  = 1'b0;
         data_out_req = 1'b0;
         data_out     = 8'h00;
         null_pkt     = 1'b0;
         sync_err     = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_HUNT;
         mode_q   <= MODE_PASS;
         pos_q    <= '0;
         hits_q   <= 8'd0;
         misses_q <= 8'd0;
      end else begin
         state_q  <= state_d;
         mode_q   <= mode_d;
         pos_q    <= pos_d;
         hits_q   <= hits_d;
         misses_q <= misses_d;
      end
   end

endmodule

// File: tb/tb_zl_ts_aligner.sv
// tb/tb_zl_ts_aligner.sv - self-checking bench for zl_ts_aligner
module tb_zl_ts_aligner;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] data_in;
   logic       data_in_req;
   logic       data_in_ack;
   logic [7:0] data_out;
   logic       data_out_req;
   logic       data_out_ack;
   logic       locked;
   logic       null_pkt;
   logic       sync_err;

   zl_ts_aligner #(
      .Lock_count     (3),
      .Unlock_count   (3),
      .Null_insert_en (1'b1)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .data_in      (data_in),
      .data_in_req  (data_in_req),
      .data_in_ack  (data_in_ack),
      .data_out     (data_out),
      .data_out_req (data_out_req),
      .data_out_ack (data_out_ack),
      .locked       (locked),
      .null_pkt     (null_pkt),
      .sync_err     (sync_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         idx;
      logic [7:0] exp_byte;
   } null_vec_t;

   null_vec_t  null_tbl [7];
   logic [7:0] pkts [32][188];
   logic [7:0] in_q [$];
   logic [7:0] out_q [$];

   int   n_checks = 0;
   int   n_errors = 0;
   int   null_cnt = 0;
   int   serr_cnt = 0;
   bit   in_en = 1'b1;
   bit   ack_rand = 1'b0;
   bit   prev_stall = 1'b0;
   logic [7:0] prev_data = 8'h00;
   bit   saw_unlock = 1'b0;
   logic first_locked = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   // One clock: drive inputs after the falling edge, then sample what will
   // transfer on the next rising edge.
   task automatic step();
      @(negedge clk);
      data_in_req = in_en && (in_q.size() > 0);
      data_in     = 8'h00;
      if (data_in_req) data_in = in_q[0];
      data_out_ack = ack_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (prev_stall && data_out_req) chk("stable", int'(data_out), int'(prev_data));
      if (data_in_req && data_in_ack) void'(in_q.pop_front());
      if (data_out_req && data_out_ack) begin
         if (out_q.size() == 0) first_locked = locked;
         out_q.push_back(data_out);
      end
      if (null_pkt) null_cnt++;
      if (sync_err) serr_cnt++;
      if (!locked) saw_unlock = 1'b1;
      prev_stall = data_out_req && !data_out_ack;
      prev_data  = data_out;
   endtask

   task automatic run_out(input string name, input int target, input int limit);
      int n = 0;
      while (out_q.size() < target && n < limit) begin
         step();
         n++;
      end
      chk({name, "_len"}, out_q.size(), target);
   endtask

   task automatic push_pkt(input int p);
      for (int i = 0; i < 188; i++) in_q.push_back(pkts[p][i]);
   endtask

   // Every forwarded packet leaves with a 0x47 sync, whatever its input sync was.
   task automatic check_pkt(input string name, input int base, input int p);
      int         mism = 0;
      logic [7:0] exp;
      for (int i = 0; i < 188; i++) begin
         exp = (i == 0) ? 8'h47 : pkts[p][i];
         if (base + i >= out_q.size()) mism++;
         else if (out_q[base + i] !== exp) mism++;
      end
      chk(name, mism, 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_in_ack"},  int'(data_in_ack), 0);
      chk({tag, "_out_req"}, int'(data_out_req), 0);
      chk({tag, "_out"},     int'(data_out), 0);
      chk({tag, "_locked"},  int'(locked), 0);
      chk({tag, "_null"},    int'(null_pkt), 0);
      chk({tag, "_serr"},    int'(sync_err), 0);
   endtask

   initial begin
      int b;
      int base;
      int cnt;
      int mism;
      logic [7:0] e;

      null_tbl[0] = '{0,   8'h47};
      null_tbl[1] = '{1,   8'h1F};
      null_tbl[2] = '{2,   8'hFF};
      null_tbl[3] = '{3,   8'h10};
      null_tbl[4] = '{4,   8'hFF};
      null_tbl[5] = '{100, 8'hFF};
      null_tbl[6] = '{187, 8'hFF};

      // Payloads avoid 0x47 so HUNT never latches onto a payload byte.
      for (int p = 0; p < 32; p++) begin
         for (int i = 0; i < 188; i++) begin
            b = (p * 13 + i * 5 + 1) & 255;
            if (b == 8'h47) b = 8'h46;
            pkts[p][i] = 8'(b);
         end
         pkts[p][0] = (p == 8 || p == 10 || p == 11 || p == 12) ? 8'h00 : 8'h47;
      end

      // Reset state, with a sync byte offered so the pop strobe must stay low.
      rst_n = 1'b0;
      data_in_req = 1'b1;
      data_in = 8'h47;
      data_out_ack = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      check_reset_outputs("rst");
      @(negedge clk);
      data_in_req = 1'b0;
      rst_n = 1'b1;

      // Junk then five packets: packets 3..5 come out.
      in_q.push_back(8'h00);
      in_q.push_back(8'h11);
      in_q.push_back(8'h22);
      for (int p = 1; p <= 5; p++) push_pkt(p);
      run_out("lock", 564, 2000);
      chk("first_out_locked", int'(first_locked), 1);
      check_pkt("pkt3", 0, 3);
      check_pkt("pkt4", 188, 4);
      check_pkt("pkt5", 376, 5);
      chk("lock_in_drained", in_q.size(), 0);
      chk("lock_no_null", null_cnt, 0);

      // Starved boundary: a full null packet, refill mid-null is held back.
      run_out("null_a", 614, 200);
      push_pkt(6);
      run_out("null_b", 752, 300);
      chk("null_refill_held", in_q.size(), 188);
      chk("null_cnt", null_cnt, 1);
      foreach (null_tbl[k]) begin
         if (564 + null_tbl[k].idx < out_q.size())
            chk($sformatf("null_byte%0d", null_tbl[k].idx),
                int'(out_q[564 + null_tbl[k].idx]), int'(null_tbl[k].exp_byte));
      end
      mism = 0;
      for (int i = 4; i < 188; i++) if (out_q[564 + i] !== 8'hFF) mism++;
      chk("null_fill", mism, 0);
      push_pkt(7);

      // Input withheld at pos 100 of packet 7.
      run_out("pkt6_out", 752 + 188 + 100, 600);
      check_pkt("pkt6", 752, 6);
      in_en = 1'b0;
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (data_out_req) cnt++;
      end
      chk("starve_req", cnt, 0);
      chk("starve_no_null", null_cnt, 1);
      in_en = 1'b1;
      for (int p = 8; p <= 16; p++) push_pkt(p);
      run_out("pkt7_out", 1128, 300);
      chk("starve_resume", int'(out_q[1040]), int'(pkts[7][100]));
      check_pkt("pkt7", 940, 7);

      // Single bad sync, then three in a row.
      run_out("serr1", 1504, 600);
      check_pkt("pkt8", 1128, 8);
      check_pkt("pkt9", 1316, 9);
      chk("serr1_cnt", serr_cnt, 1);
      chk("serr1_locked", int'(locked), 1);
      saw_unlock = 1'b0;
      run_out("serr3", 1880, 600);
      check_pkt("pkt10", 1504, 10);
      check_pkt("pkt11", 1692, 11);
      run_out("relock", 2068, 1500);
      chk("serr3_cnt", serr_cnt, 3);
      chk("serr3_unlocked", int'(saw_unlock), 1);
      check_pkt("pkt15", 1880, 15);

      // Random downstream back-pressure over ten packets.
      for (int p = 17; p <= 25; p++) push_pkt(p);
      ack_rand = 1'b1;
      run_out("rand", 2068 + 1880, 20000);
      ack_rand = 1'b0;
      prev_stall = 1'b0;
      for (int p = 16; p <= 25; p++)
         check_pkt($sformatf("rand_pkt%0d", p), 2068 + (p - 16) * 188, p);
      chk("rand_no_null", null_cnt, 1);

      // Reset asserted at pos 90 of a passing packet.
      base = out_q.size();
      push_pkt(26);
      push_pkt(27);
      run_out("pre_rst", base + 90, 400);
      @(negedge clk);
      data_in_req = 1'b1;
      data_in = in_q[0];
      data_out_ack = 1'b1;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midrst");
      repeat (2) @(negedge clk);
      data_in_req = 1'b0;
      rst_n = 1'b1;
      in_q.delete();
      for (int p = 28; p <= 31; p++) push_pkt(p);
      run_out("post_rst", base + 90 + 376, 1500);
      check_pkt("pkt30", base + 90, 30);
      check_pkt("pkt31", base + 90 + 188, 31);
      chk("post_rst_locked", int'(locked), 1);
      e = out_q[base + 89];
      chk("pre_rst_byte89", int'(e), int'(pkts[26][89]));

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
